param_fifo: RTL and testbench

Parametrised synchronous FIFO for the mlp_conv datapath, replacing the fixed 32x32 fifo wherever producers and consumers need occupancy feedback. It adds:
- any depth of 2 or more, including non-power-of-2 depths;
- programmable almost-full and almost-empty thresholds, plus an occupancy count;
- synchronous flush, and sticky overflow/underflow error flags;
- optional first-word-fall-through read mode.

It sits between the MLP/conv compute stages and the AXI-side buffers.

---
 rtl/mlp_conv_pkg.sv | 21 ++
 rtl/fifo_ptr.sv | 39 +++
 rtl/param_fifo.sv | 148 ++++++++++++++
 tb/tb_param_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mlp_conv_pkg.sv
// Shared constants and types for the mlp_conv datapath FIFOs.
package mlp_conv_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 32;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Pointer width that can address DEPTH entries (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer for param_fifo: counts 0..DEPTH-1 then returns to 0.
module fifo_ptr
    import mlp_conv_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic             INC,
    output logic [PTR_W-1:0] PTR
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (CLR) begin
            ptr_d = '0;
        end else if (INC) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign PTR = ptr_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with thresholds, flush and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module param_fifo
    import mlp_conv_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  WR_CMD,
    input  logic [FIFO_WIDTH-1:0] WR_DATA,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    input  logic                  RD_CMD,
    output logic [FIFO_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic [CNT_W-1:0]      COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  CLR_ERR
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_accept, rd_accept;
    logic                  wr_drop, rd_reject;
    fifo_status_t          status;

    assign status.full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign status.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign status.empty        = (count_q == '0);
    assign status.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign status.overflow     = overflow_q;
    assign status.underflow    = underflow_q;

    // FLUSH masks both commands, so it also suppresses error reporting.
    assign rd_accept = RD_CMD && !status.empty && !FLUSH;
    assign wr_accept = WR_CMD && (!status.full || rd_accept) && !FLUSH;
    assign wr_drop   = WR_CMD && !FLUSH && !wr_accept;
    assign rd_reject = RD_CMD && !FLUSH && !rd_accept;

    fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (FLUSH),
        .INC   (wr_accept),
        .PTR   (wr_ptr)
    );

    fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (FLUSH),
        .INC   (rd_accept),
        .PTR   (rd_ptr)
    );

    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    always_comb begin
        count_d = count_q;
        if (FLUSH) begin
            count_d = '0;
        end else if (wr_accept && !rd_accept) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Set wins over CLR_ERR when both happen in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (CLR_ERR) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_drop) begin
            overflow_d = 1'b1;
        end
        if (rd_reject) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is presented directly; zero while empty so reset value holds.
    assign RD_DATA  = status.empty ? '0 : mem[rd_ptr];
    assign RD_VALID = !status.empty;
`else
    logic [FIFO_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= mem[rd_ptr];
            end
        end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
`endif

    assign FULL         = status.full;
    assign ALMOST_FULL  = status.almost_full;
    assign EMPTY        = status.empty;
    assign ALMOST_EMPTY = status.almost_empty;
    assign COUNT        = count_q;
    assign OVERFLOW     = status.overflow;
    assign UNDERFLOW    = status.underflow;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a depth-32 and a depth-5 instance checked every cycle
// against queue-based reference models.
module tb_param_fifo;

    localparam int unsigned DEP [2] = '{32, 5};
    localparam int unsigned AFT [2] = '{30, 3};
    localparam int unsigned AET [2] = '{2, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        wr [2];
    logic        rd [2];
    logic        fl [2];
    logic        clr [2];
    logic [31:0] wd [2];

    logic        full [2];
    logic        af [2];
    logic        empty [2];
    logic        ae [2];
    logic        rdv [2];
    logic        ovf [2];
    logic        udf [2];
    logic [31:0] rdd [2];
    logic [5:0]  cnt_a;
    logic [2:0]  cnt_b;

    logic [31:0] mq [2][$];
    logic        m_ovf [2];
    logic        m_udf [2];
    logic        m_rdv [2];
    logic [31:0] m_rdd [2];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    param_fifo u_d32 (
        .CLK          (clk),
        .RESET        (rst),
        .FLUSH        (fl[0]),
        .WR_CMD       (wr[0]),
        .WR_DATA      (wd[0]),
        .FULL         (full[0]),
        .ALMOST_FULL  (af[0]),
        .RD_CMD       (rd[0]),
        .RD_DATA      (rdd[0]),
        .RD_VALID     (rdv[0]),
        .EMPTY        (empty[0]),
        .ALMOST_EMPTY (ae[0]),
        .COUNT        (cnt_a),
        .OVERFLOW     (ovf[0]),
        .UNDERFLOW    (udf[0]),
        .CLR_ERR      (clr[0])
    );

    param_fifo #(.FIFO_DEPTH(5)) u_d5 (
        .CLK          (clk),
        .RESET        (rst),
        .FLUSH        (fl[1]),
        .WR_CMD       (wr[1]),
        .WR_DATA      (wd[1]),
        .FULL         (full[1]),
        .ALMOST_FULL  (af[1]),
        .RD_CMD       (rd[1]),
        .RD_DATA      (rdd[1]),
        .RD_VALID     (rdv[1]),
        .EMPTY        (empty[1]),
        .ALMOST_EMPTY (ae[1]),
        .COUNT        (cnt_b),
        .OVERFLOW     (ovf[1]),
        .UNDERFLOW    (udf[1]),
        .CLR_ERR      (clr[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic reset_models();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
            m_rdv[i] = 1'b0;
            m_rdd[i] = '0;
        end
    endtask

    // Applies the FIFO rules to the inputs that were present at the last edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int sz = mq[i].size();
            bit ra, wa, so, su;
            ra = rd[i] && (sz > 0) && !fl[i];
            wa = wr[i] && !fl[i] && ((sz < int'(DEP[i])) || ra);
            so = wr[i] && !fl[i] && !wa;
            su = rd[i] && !fl[i] && !ra;
            if (fl[i]) begin
                mq[i].delete();
            end else begin
                if (ra) m_rdd[i] = mq[i].pop_front();
                if (wa) mq[i].push_back(wd[i]);
            end
            m_rdv[i] = ra;
            m_ovf[i] = so ? 1'b1 : (clr[i] ? 1'b0 : m_ovf[i]);
            m_udf[i] = su ? 1'b1 : (clr[i] ? 1'b0 : m_udf[i]);
        end
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < 2; i++) begin
            int sz = mq[i].size();
            string p = $sformatf("%s.d%0d", ph, DEP[i]);
            chk({p, ".count"}, (i == 0) ? 64'(cnt_a) : 64'(cnt_b), 64'(sz));
            chk({p, ".empty"}, 64'(empty[i]), 64'(sz == 0));
            chk({p, ".full"}, 64'(full[i]), 64'(sz == int'(DEP[i])));
            chk({p, ".almost_full"}, 64'(af[i]), 64'(sz >= int'(AFT[i])));
            chk({p, ".almost_empty"}, 64'(ae[i]), 64'(sz <= int'(AET[i])));
            chk({p, ".overflow"}, 64'(ovf[i]), 64'(m_ovf[i]));
            chk({p, ".underflow"}, 64'(udf[i]), 64'(m_udf[i]));
            chk({p, ".rd_valid"}, 64'(rdv[i]), 64'(m_rdv[i]));
            chk({p, ".rd_data"}, 64'(rdd[i]), 64'(m_rdd[i]));
        end
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        #1;
        model_step();
        check_all(ph);
    endtask

    task automatic set_a(input logic w, input logic r, input logic [31:0] d,
                         input logic f, input logic c);
        wr[0]  = w;
        rd[0]  = r;
        wd[0]  = d;
        fl[0]  = f;
        clr[0] = c;
    endtask

    task automatic rand_in(input int i);
        wr[i]  = ($urandom_range(0, 99) < 55);
        rd[i]  = ($urandom_range(0, 99) < 50);
        wd[i]  = $urandom;
        fl[i]  = ($urandom_range(0, 63) == 0);
        clr[i] = !fl[i] && ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr[i] = 0; rd[i] = 0; fl[i] = 0; clr[i] = 0; wd[i] = '0;
        end
        reset_models();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 32; k++) begin
            set_a(1, 0, $urandom, 0, 0); rand_in(1); tick("fill");
        end
        chk("fill.full_flag", 64'(full[0]), 64'd1);
        chk("fill.count32", 64'(cnt_a), 64'd32);

        set_a(1, 0, 32'hDEADBEEF, 0, 0); rand_in(1); tick("overflow");
        chk("overflow.flag", 64'(ovf[0]), 64'd1);
        set_a(0, 0, 0, 0, 1); rand_in(1); tick("clr_err");
        chk("clr_err.flag", 64'(ovf[0]), 64'd0);

        for (int k = 0; k < 100; k++) begin
            set_a(1, 1, $urandom, 0, 0); rand_in(1); tick("full_rw");
        end
        chk("full_rw.count32", 64'(cnt_a), 64'd32);

        for (int k = 0; k < 32; k++) begin
            set_a(0, 1, 0, 0, 0); rand_in(1); tick("drain");
        end
        chk("drain.empty", 64'(empty[0]), 64'd1);
        set_a(0, 1, 0, 0, 0); rand_in(1); tick("underflow");
        chk("underflow.flag", 64'(udf[0]), 64'd1);
        set_a(0, 0, 0, 0, 1); rand_in(1); tick("clr_err2");

        set_a(1, 1, $urandom, 0, 0); rand_in(1); tick("empty_rw");
        chk("empty_rw.count1", 64'(cnt_a), 64'd1);
        chk("empty_rw.underflow", 64'(udf[0]), 64'd1);

        for (int k = 0; k < 9; k++) begin
            set_a(1, 0, $urandom, 0, 0); rand_in(1); tick("pre_flush");
        end
        chk("pre_flush.count10", 64'(cnt_a), 64'd10);
        set_a(1, 0, $urandom, 1, 0); rand_in(1); tick("flush");
        chk("flush.count0", 64'(cnt_a), 64'd0);

        for (int k = 0; k < 300; k++) begin
            rand_in(0); rand_in(1); tick("random1");
        end

        // Async reset lands between edges; outputs must clear before the next edge.
        #2 rst = 1'b1;
        #1;
        reset_models();
        check_all("async_rst");
        #2 rst = 1'b0;

        for (int k = 0; k < 500; k++) begin
            rand_in(0); rand_in(1); tick("random2");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
